// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display path.
// Segment vectors are {g,f,e,d,c,b,a}, active-low: a 0 lights the segment.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef logic [6:0]       seg_t;
  typedef logic [IDX_W-1:0] digit_idx_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Full 16-entry nibble table; codes 10..15 are not BCD and show a dash.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    SEG_DASH,    // 10
    SEG_DASH,    // 11
    SEG_DASH,    // 12
    SEG_DASH,    // 13
    SEG_DASH,    // 14
    SEG_DASH     // 15
  };

  // Active-low one-hot anode pattern for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_enable(input digit_idx_t idx);
    digit_enable = ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to seven-segment decoder (active-low segments).
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Decimal digits use the standard glyphs; anything above 9 renders as a dash.
  always_comb begin
    if (nibble > 4'd9) begin
      seg = SEG_DASH;
    end else begin
      seg = SEG_TABLE[nibble];
    end
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Four-digit time-multiplexed BCD display driver with frame-synchronous
// update: new values wait in a pending register and only reach the display
// register at the 3->0 digit wrap, so a frame never mixes two values.
module bcd_display_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] bcd_i,
  input  logic        load_i,
  input  logic [3:0]  dp_i,
  input  logic        lzb_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        pend_o
);

  localparam int CNT_W = $clog2(DIGIT_TICKS);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam digit_idx_t       IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);

  // Stage p0: scan timing, pending and display registers.
  logic [CNT_W-1:0] cnt_p0;
  digit_idx_t       idx_p0;
  logic [15:0]      pend_val_p0;
  logic             pend_p0;
  logic [15:0]      disp_p0;

  // Stage p1: registered pin drivers.
  logic [3:0]       an_p1;
  seg_t             seg_p1;
  logic             dp_p1;

  logic             tick;
  logic             commit;
  logic [3:0]       sel_nibble;
  seg_t             dec_seg;
  logic [3:0]       blank;
  logic [3:0]       nib_zero;

  assign tick   = (cnt_p0 == TICK_LAST);
  assign commit = tick && (idx_p0 == IDX_LAST);

  // Per-digit dwell counter and digit index; the index advances on each tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (tick) begin
      cnt_p0 <= '0;
      idx_p0 <= idx_p0 + digit_idx_t'(1);
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // Pending capture and frame-boundary commit; a load on the commit tick
  // bypasses the pending register so it is never left set afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_val_p0 <= '0;
      pend_p0     <= 1'b0;
      disp_p0     <= '0;
    end else if (commit) begin
      if (load_i) begin
        disp_p0 <= bcd_i;
      end else if (pend_p0) begin
        disp_p0 <= pend_val_p0;
      end
      pend_p0 <= 1'b0;
    end else if (load_i) begin
      pend_val_p0 <= bcd_i;
      pend_p0     <= 1'b1;
    end
  end

  // Select the nibble for the digit currently being driven.
  assign sel_nibble = disp_p0[{idx_p0, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  // Leading-zero blanking: digit k blanks when it and every higher digit are
  // zero; digit 0 always shows so a zero value still displays "0".
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib_zero[k] = (disp_p0[4*k +: 4] == 4'd0);
    end
    blank    = 4'b0000;
    blank[3] = lzb_i & nib_zero[3];
    blank[2] = lzb_i & nib_zero[3] & nib_zero[2];
    blank[1] = lzb_i & nib_zero[3] & nib_zero[2] & nib_zero[1];
  end

  // Register the pin drivers; reset holds every digit and segment dark.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      an_p1  <= 4'b1111;
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= digit_enable(idx_p0);
      seg_p1 <= blank[idx_p0] ? SEG_BLANK : dec_seg;
      dp_p1  <= ~dp_i[idx_p0];
    end
  end

  assign an_o   = an_p1;
  assign seg_o  = seg_p1;
  assign dp_o   = dp_p1;
  assign pend_o = pend_p0;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomised and directed checks of bcd_display_mux against a cycle-count
// reference model (DIGIT_TICKS = 4, so a frame is 16 cycles).
module tb_bcd_display_mux;

  localparam int DT    = 4;
  localparam int FRAME = 4 * DT;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] bcd_i  = 16'h0000;
  logic        load_i = 1'b0;
  logic [3:0]  dp_i   = 4'b0000;
  logic        lzb_i  = 1'b0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        pend_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state: n = cycles since reset release.
  int          n = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pval = 16'h0000;
  logic        m_pend = 1'b0;
  logic [3:0]  e_an   = 4'hF;
  logic [6:0]  e_seg  = 7'h7F;
  logic        e_dp   = 1'b1;
  logic [6:0]  ref_pat [16];

  always #5 clk_i = ~clk_i;

  bcd_display_mux #(.DIGIT_TICKS(DT)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bcd_i  (bcd_i),
    .load_i (load_i),
    .dp_i   (dp_i),
    .lzb_i  (lzb_i),
    .an_o   (an_o),
    .seg_o  (seg_o),
    .dp_o   (dp_o),
    .pend_o (pend_o)
  );

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int k, input logic lzb);
    logic [15:0] hi;
    hi = v >> (4 * k);
    if (k > 0 && lzb && hi == 16'h0000) return 7'h7F;
    return ref_pat[hi[3:0]];
  endfunction

  // One clock: advance the model with the inputs present before the edge,
  // then settle 1 time unit past the edge for sampling.
  task automatic step();
    logic        c_rst, c_ld, c_lzb;
    logic [15:0] c_bcd;
    logic [3:0]  c_dp;
    int          k;
    c_rst = rst_ni; c_ld = load_i; c_lzb = lzb_i; c_bcd = bcd_i; c_dp = dp_i;
    @(posedge clk_i);
    if (!c_rst) begin
      n = 0; m_disp = 16'h0000; m_pval = 16'h0000; m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      k = (n / DT) % 4;
      e_an = 4'hF;
      e_an[k] = 1'b0;
      e_seg = ref_seg(m_disp, k, c_lzb);
      e_dp = ~c_dp[k];
      if (n % FRAME == FRAME - 1) begin
        if (c_ld) m_disp = c_bcd;
        else if (m_pend) m_disp = m_pval;
        m_pend = 1'b0;
      end else if (c_ld) begin
        m_pval = c_bcd;
        m_pend = 1'b1;
      end
      n++;
    end
    #1;
  endtask

  // Step until the next edge is the given position within the frame.
  task automatic goto_phase(input int phase);
    for (int i = 0; i < FRAME && (n % FRAME) != phase; i++) step();
  endtask

  task automatic load_value(input logic [15:0] v);
    bcd_i = v; load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step(); step();
    checks++; if (an_o !== 4'hF) begin failures++; $display("FAIL reset_an: got %b want 1111", an_o); end
    checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %b want 1111111", seg_o); end
    checks++; if (dp_o !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", dp_o); end
    checks++; if (pend_o !== 1'b0) begin failures++; $display("FAIL reset_pend: got %b want 0", pend_o); end
    rst_ni = 1'b1;
    step();
    checks++; if (an_o !== 4'b1110) begin failures++; $display("FAIL first_an: got %b want 1110", an_o); end
    checks++; if (seg_o !== 7'b1000000) begin failures++; $display("FAIL first_seg: got %b want 1000000", seg_o); end
  endtask

  task automatic test_scan();
    dp_i = 4'($urandom_range(0, 15));
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++; if (an_o !== e_an) begin failures++; $display("FAIL scan_an c%0d: got %b want %b", i, an_o, e_an); end
      checks++; if (seg_o !== e_seg) begin failures++; $display("FAIL scan_seg c%0d: got %b want %b", i, seg_o, e_seg); end
      checks++; if (dp_o !== e_dp) begin failures++; $display("FAIL scan_dp c%0d: got %b want %b", i, dp_o, e_dp); end
    end
    dp_i = 4'b0000;
  endtask

  task automatic test_load_commit();
    lzb_i = 1'b0;
    goto_phase(5);
    load_value(16'h1234);
    checks++; if (pend_o !== 1'b1) begin failures++; $display("FAIL pend_set: got %b want 1", pend_o); end
    while (n % FRAME != 0) begin
      step();
      checks++; if (pend_o !== m_pend) begin failures++; $display("FAIL pend_wait n%0d: got %b want %b", n, pend_o, m_pend); end
    end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (seg_o !== e_seg || an_o !== e_an) begin failures++; $display("FAIL show1234 c%0d: got %b/%b want %b/%b", i, an_o, seg_o, e_an, e_seg); end
      if (i == 0) begin checks++; if (seg_o !== 7'b0011001) begin failures++; $display("FAIL show1234_d0: got %b want 0011001", seg_o); end end
      if (i == 3 * DT) begin checks++; if (seg_o !== 7'b1111001) begin failures++; $display("FAIL show1234_d3: got %b want 1111001", seg_o); end end
    end
  endtask

  task automatic test_lzb();
    lzb_i = 1'b1;
    goto_phase(5);
    load_value(16'h0056);
    goto_phase(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (seg_o !== e_seg) begin failures++; $display("FAIL lzb56 c%0d: got %b want %b", i, seg_o, e_seg); end
      if (i == 0)      begin checks++; if (seg_o !== 7'b0000010) begin failures++; $display("FAIL lzb56_d0: got %b want 0000010", seg_o); end end
      if (i == DT)     begin checks++; if (seg_o !== 7'b0010010) begin failures++; $display("FAIL lzb56_d1: got %b want 0010010", seg_o); end end
      if (i == 2 * DT) begin checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL lzb56_d2: got %b want 1111111", seg_o); end end
      if (i == 3 * DT) begin checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL lzb56_d3: got %b want 1111111", seg_o); end end
    end
    load_value(16'h0000);
    goto_phase(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (seg_o !== ((i < DT) ? 7'b1000000 : 7'h7F)) begin failures++; $display("FAIL lzb0 c%0d: got %b want %b", i, seg_o, e_seg); end
    end
    lzb_i = 1'b0;
  endtask

  task automatic test_dash_dp();
    dp_i = 4'b0100;
    goto_phase(5);
    load_value(16'h00A9);
    goto_phase(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (dp_o !== e_dp || seg_o !== e_seg) begin failures++; $display("FAIL dash_dp c%0d: got %b/%b want %b/%b", i, dp_o, seg_o, e_dp, e_seg); end
      checks++; if (dp_o !== ((i / DT == 2) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL dp_digit2 c%0d: got %b", i, dp_o); end
      if (i == DT) begin checks++; if (seg_o !== 7'b0111111) begin failures++; $display("FAIL dash_d1: got %b want 0111111", seg_o); end end
    end
    dp_i = 4'b0000;
  endtask

  task automatic test_back_to_back();
    goto_phase(3);
    load_value(16'h1111);
    load_value(16'h2222);
    goto_phase(0);
    step();
    checks++; if (seg_o !== 7'b0100100) begin failures++; $display("FAIL last_wins: got %b want 0100100", seg_o); end
    goto_phase(FRAME - 1);
    load_value(16'h7890);
    checks++; if (pend_o !== 1'b0) begin failures++; $display("FAIL commit_tick_pend: got %b want 0", pend_o); end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (pend_o !== 1'b0 || seg_o !== e_seg) begin failures++; $display("FAIL commit_tick c%0d: got %b/%b want 0/%b", i, pend_o, seg_o, e_seg); end
      if (i == 3 * DT) begin checks++; if (seg_o !== 7'b1111000) begin failures++; $display("FAIL commit_tick_d3: got %b want 1111000", seg_o); end end
    end
  endtask

  task automatic test_reset_pending();
    goto_phase(6);
    load_value(16'h4321);
    checks++; if (pend_o !== 1'b1) begin failures++; $display("FAIL rp_pend: got %b want 1", pend_o); end
    rst_ni = 1'b0;
    step();
    checks++; if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || pend_o !== 1'b0) begin failures++; $display("FAIL rp_off: got %b/%b/%b/%b want 1111/1111111/1/0", an_o, seg_o, dp_o, pend_o); end
    rst_ni = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++; if (seg_o !== 7'b1000000 || pend_o !== 1'b0) begin failures++; $display("FAIL rp_zero c%0d: got %b/%b want 1000000/0", i, seg_o, pend_o); end
      checks++; if (an_o !== e_an) begin failures++; $display("FAIL rp_an c%0d: got %b want %b", i, an_o, e_an); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst_ni = ($urandom_range(0, 99) != 0);
      load_i = ($urandom_range(0, 4) == 0);
      for (int d = 0; d < 4; d++) bcd_i[4*d +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_i  = 4'($urandom_range(0, 15));
      lzb_i = ($urandom_range(0, 1) == 1);
      step();
      checks++; if (an_o !== e_an) begin failures++; $display("FAIL rnd_an c%0d: got %b want %b", i, an_o, e_an); end
      checks++; if (seg_o !== e_seg) begin failures++; $display("FAIL rnd_seg c%0d: got %b want %b", i, seg_o, e_seg); end
      checks++; if (dp_o !== e_dp) begin failures++; $display("FAIL rnd_dp c%0d: got %b want %b", i, dp_o, e_dp); end
      checks++; if (pend_o !== m_pend) begin failures++; $display("FAIL rnd_pend c%0d: got %b want %b", i, pend_o, m_pend); end
    end
    rst_ni = 1'b1; load_i = 1'b0;
  endtask

  initial begin
    ref_pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    test_reset();
    test_scan();
    test_load_commit();
    test_lzb();
    test_dash_dp();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
